// File: rtl/ft_slave_fifo_if.sv
// FT600-style slave bus bundle: master-facing strobes/data, local load/drain
// handshakes and status. The slave modport is the bridge; master is the far side.
interface ft_slave_fifo_if;
  logic        wr_n;
  logic        rd_n;
  logic        oe_n;
  logic [15:0] data_i;
  logic [1:0]  be_i;
  logic [15:0] data_o;
  logic [1:0]  be_o;
  logic        bus_oe;
  logic        rxf_n;
  logic        txe_n;

  logic        src_valid;
  logic        src_ready;
  logic [15:0] src_data;
  logic [1:0]  src_be;

  logic        snk_valid;
  logic        snk_ready;
  logic [15:0] snk_data;
  logic [1:0]  snk_be;

  logic        proto_err;
  logic [15:0] rd_words;
  logic [15:0] wr_words;

  modport slave (
    input  wr_n, rd_n, oe_n, data_i, be_i,
    input  src_valid, src_data, src_be, snk_ready,
    output data_o, be_o, bus_oe, rxf_n, txe_n,
    output src_ready, snk_valid, snk_data, snk_be,
    output proto_err, rd_words, wr_words
  );

  modport master (
    output wr_n, rd_n, oe_n, data_i, be_i,
    output src_valid, src_data, src_be, snk_ready,
    input  data_o, be_o, bus_oe, rxf_n, txe_n,
    input  src_ready, snk_valid, snk_data, snk_be,
    input  proto_err, rd_words, wr_words
  );
endinterface

// File: rtl/ft_slave_fifo.sv
// FT600-style synchronous slave bridge: read buffer (local->master) and write
// buffer (master->local), zero-wait bursts, registered RXF#/TXE#, sticky protocol error.
module ft_slave_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  ft_slave_fifo_if.slave bus
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OE    = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   err_set;
  logic   proto_err_q;

  // Read buffer (local source -> master)
  logic [17:0]   rb_mem_q [DEPTH];
  logic [AW-1:0] rb_wptr_q, rb_rptr_q;
  logic [AW:0]   rb_cnt_q, rb_cnt_d;
  logic          rb_push, rb_pop;

  // Write buffer (master -> local sink)
  logic [17:0]   wb_mem_q [DEPTH];
  logic [AW-1:0] wb_wptr_q, wb_rptr_q;
  logic [AW:0]   wb_cnt_q, wb_cnt_d;
  logic          wb_push, wb_pop;

  logic          rxf_n_q, txe_n_q;
  logic [15:0]   rd_words_q, wr_words_q;
  logic          st_read_side, st_write_side;

  assign st_read_side  = (state_q == S_OE) || (state_q == S_READ);
  assign st_write_side = (state_q == S_IDLE) || (state_q == S_WRITE);

  assign rb_push = bus.src_valid && (rb_cnt_q != FULL);
  assign rb_pop  = st_read_side && !bus.rd_n && !rxf_n_q;
  assign wb_push = st_write_side && !bus.wr_n && bus.oe_n && !txe_n_q;
  assign wb_pop  = (wb_cnt_q != '0) && bus.snk_ready;

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!bus.oe_n && !bus.wr_n) err_set = 1'b1;
        else if (!bus.oe_n)         state_d = S_OE;
        else if (!bus.wr_n)         state_d = S_WRITE;
        if (!bus.rd_n) err_set = 1'b1;
      end
      S_OE: begin
        if (!bus.wr_n) err_set = 1'b1;
        if (bus.oe_n)       state_d = S_IDLE;
        else if (!bus.rd_n) state_d = S_READ;
      end
      S_READ: begin
        if (!bus.wr_n) err_set = 1'b1;
        if (bus.oe_n) state_d = S_IDLE;
      end
      S_WRITE: begin
        if (!bus.rd_n) err_set = 1'b1;
        if (bus.wr_n) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rb_cnt_d = rb_cnt_q;
    case ({rb_push, rb_pop})
      2'b10:   rb_cnt_d = rb_cnt_q + 1'b1;
      2'b01:   rb_cnt_d = rb_cnt_q - 1'b1;
      default: rb_cnt_d = rb_cnt_q;
    endcase
  end

  always_comb begin
    wb_cnt_d = wb_cnt_q;
    case ({wb_push, wb_pop})
      2'b10:   wb_cnt_d = wb_cnt_q + 1'b1;
      2'b01:   wb_cnt_d = wb_cnt_q - 1'b1;
      default: wb_cnt_d = wb_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      proto_err_q <= 1'b0;
      rb_wptr_q   <= '0;
      rb_rptr_q   <= '0;
      rb_cnt_q    <= '0;
      wb_wptr_q   <= '0;
      wb_rptr_q   <= '0;
      wb_cnt_q    <= '0;
      rxf_n_q     <= 1'b1;
      txe_n_q     <= 1'b0;
      rd_words_q  <= '0;
      wr_words_q  <= '0;
    end else begin
      state_q  <= state_d;
      if (err_set) proto_err_q <= 1'b1;
      rb_cnt_q <= rb_cnt_d;
      wb_cnt_q <= wb_cnt_d;
      // Flags look at next-state counts so they are never a cycle stale.
      rxf_n_q  <= (rb_cnt_d == '0);
      txe_n_q  <= (wb_cnt_d == FULL);
      if (rb_push) rb_wptr_q <= rb_wptr_q + 1'b1;
      if (rb_pop) begin
        rb_rptr_q  <= rb_rptr_q + 1'b1;
        rd_words_q <= rd_words_q + 16'd1;
      end
      if (wb_push) begin
        wb_wptr_q  <= wb_wptr_q + 1'b1;
        wr_words_q <= wr_words_q + 16'd1;
      end
      if (wb_pop) wb_rptr_q <= wb_rptr_q + 1'b1;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counts.
  always_ff @(posedge clk) begin
    if (!rst && rb_push) rb_mem_q[rb_wptr_q] <= {bus.src_be, bus.src_data};
    if (!rst && wb_push) wb_mem_q[wb_wptr_q] <= {bus.be_i, bus.data_i};
  end

  assign bus.data_o    = (rb_cnt_q == '0) ? 16'h0000 : rb_mem_q[rb_rptr_q][15:0];
  assign bus.be_o      = (rb_cnt_q == '0) ? 2'b00    : rb_mem_q[rb_rptr_q][17:16];
  assign bus.bus_oe    = st_read_side;
  assign bus.rxf_n     = rxf_n_q;
  assign bus.txe_n     = txe_n_q;
  assign bus.src_ready = (rb_cnt_q != FULL);
  assign bus.snk_valid = (wb_cnt_q != '0);
  assign bus.snk_data  = wb_mem_q[wb_rptr_q][15:0];
  assign bus.snk_be    = wb_mem_q[wb_rptr_q][17:16];
  assign bus.proto_err = proto_err_q;
  assign bus.rd_words  = rd_words_q;
  assign bus.wr_words  = wr_words_q;

endmodule

// File: tb/tb_ft_slave_fifo.sv
// Directed bench for ft_slave_fifo: bursts, full/empty boundaries, protocol errors, reset, counter wrap.
module tb_ft_slave_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  ft_slave_fifo_if bus ();

  ft_slave_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_n = 1'b1; bus.rd_n = 1'b1; bus.oe_n = 1'b1;
    bus.data_i = 16'h0; bus.be_i = 2'b00;
    bus.src_valid = 1'b0; bus.src_data = 16'h0; bus.src_be = 2'b00;
    bus.snk_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    total++; if (bus.rxf_n !== 1'b1) $display("FAIL reset_rxf_n got %b exp 1", bus.rxf_n); else passed++;
    total++; if (bus.txe_n !== 1'b0) $display("FAIL reset_txe_n got %b exp 0", bus.txe_n); else passed++;
    total++; if (bus.proto_err !== 1'b0) $display("FAIL reset_proto_err got %b exp 0", bus.proto_err); else passed++;
    total++; if (bus.rd_words !== 16'h0) $display("FAIL reset_rd_words got %h exp 0", bus.rd_words); else passed++;
    total++; if (bus.wr_words !== 16'h0) $display("FAIL reset_wr_words got %h exp 0", bus.wr_words); else passed++;
    total++; if (bus.src_ready !== 1'b1) $display("FAIL reset_src_ready got %b exp 1", bus.src_ready); else passed++;
    total++; if (bus.snk_valid !== 1'b0) $display("FAIL reset_snk_valid got %b exp 0", bus.snk_valid); else passed++;
    total++; if (bus.bus_oe !== 1'b0) $display("FAIL reset_bus_oe got %b exp 0", bus.bus_oe); else passed++;
    total++; if (bus.data_o !== 16'h0) $display("FAIL reset_data_o got %h exp 0", bus.data_o); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_read_burst();
    bus.src_valid = 1'b1; bus.src_be = 2'b11;
    bus.src_data = 16'h1111; step();
    bus.src_data = 16'h2222; step();
    bus.src_data = 16'h3333; step();
    bus.src_valid = 1'b0;
    total++; if (bus.rxf_n !== 1'b0) $display("FAIL rb_rxf_n_loaded got %b exp 0", bus.rxf_n); else passed++;
    total++; if (bus.be_o !== 2'b11) $display("FAIL rb_be_o got %b exp 11", bus.be_o); else passed++;
    bus.oe_n = 1'b0; step();
    total++; if (bus.bus_oe !== 1'b1) $display("FAIL rb_bus_oe got %b exp 1", bus.bus_oe); else passed++;
    total++; if (bus.data_o !== 16'h1111) $display("FAIL rb_word0 got %h exp 1111", bus.data_o); else passed++;
    bus.rd_n = 1'b0; step();
    total++; if (bus.data_o !== 16'h2222) $display("FAIL rb_word1 got %h exp 2222", bus.data_o); else passed++;
    step();
    total++; if (bus.data_o !== 16'h3333) $display("FAIL rb_word2 got %h exp 3333", bus.data_o); else passed++;
    total++; if (bus.rxf_n !== 1'b0) $display("FAIL rb_rxf_n_mid got %b exp 0", bus.rxf_n); else passed++;
    step();
    total++; if (bus.rxf_n !== 1'b1) $display("FAIL rb_rxf_n_empty got %b exp 1", bus.rxf_n); else passed++;
    total++; if (bus.rd_words !== 16'd3) $display("FAIL rb_rd_words got %0d exp 3", bus.rd_words); else passed++;
    total++; if (bus.data_o !== 16'h0) $display("FAIL rb_data_o_empty got %h exp 0", bus.data_o); else passed++;
    step();
    total++; if (bus.rd_words !== 16'd3) $display("FAIL rb_empty_read_ignored got %0d exp 3", bus.rd_words); else passed++;
    bus.rd_n = 1'b1; bus.oe_n = 1'b1; step();
    total++; if (bus.bus_oe !== 1'b0) $display("FAIL rb_bus_oe_off got %b exp 0", bus.bus_oe); else passed++;
    total++; if (bus.proto_err !== 1'b0) $display("FAIL rb_no_err got %b exp 0", bus.proto_err); else passed++;
  endtask

  task automatic test_write_full();
    bus.snk_ready = 1'b0; bus.oe_n = 1'b1; bus.be_i = 2'b11; bus.wr_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.data_i = 16'(i);
      step();
    end
    total++; if (bus.txe_n !== 1'b1) $display("FAIL wb_txe_n_full got %b exp 1", bus.txe_n); else passed++;
    total++; if (bus.wr_words !== 16'd16) $display("FAIL wb_wr_words got %0d exp 16", bus.wr_words); else passed++;
    total++; if (bus.snk_valid !== 1'b1) $display("FAIL wb_snk_valid got %b exp 1", bus.snk_valid); else passed++;
    bus.data_i = 16'hDEAD; bus.be_i = 2'b00; step();
    total++; if (bus.wr_words !== 16'd16) $display("FAIL wb_17th_ignored got %0d exp 16", bus.wr_words); else passed++;
    total++; if (bus.proto_err !== 1'b0) $display("FAIL wb_full_no_err got %b exp 0", bus.proto_err); else passed++;
    bus.wr_n = 1'b1; step();
    bus.snk_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.snk_data !== 16'(i)) $display("FAIL wb_drain_data[%0d] got %h exp %h", i, bus.snk_data, 16'(i)); else passed++;
      total++; if (bus.snk_be !== 2'b11) $display("FAIL wb_drain_be[%0d] got %b exp 11", i, bus.snk_be); else passed++;
      step();
    end
    total++; if (bus.snk_valid !== 1'b0) $display("FAIL wb_drained_valid got %b exp 0", bus.snk_valid); else passed++;
    total++; if (bus.txe_n !== 1'b0) $display("FAIL wb_drained_txe_n got %b exp 0", bus.txe_n); else passed++;
    bus.snk_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    do_reset();
    bus.src_valid = 1'b1; bus.src_be = 2'b01;
    for (int i = 0; i < 15; i++) begin
      bus.src_data = 16'h0100 + 16'(i);
      step();
    end
    bus.src_valid = 1'b0;
    bus.oe_n = 1'b0; step();
    bus.rd_n = 1'b0; bus.src_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.src_data = 16'h010F + 16'(k);
      exp = 16'h0100 + 16'(k);
      total++; if (bus.data_o !== exp) $display("FAIL b2b_data[%0d] got %h exp %h", k, bus.data_o, exp); else passed++;
      total++; if (bus.src_ready !== 1'b1) $display("FAIL b2b_src_ready[%0d] got %b exp 1", k, bus.src_ready); else passed++;
      step();
    end
    bus.rd_n = 1'b1;
    total++; if (bus.rd_words !== 16'd10) $display("FAIL b2b_rd_words got %0d exp 10", bus.rd_words); else passed++;
    bus.src_data = 16'h01FF; step();
    bus.src_valid = 1'b0;
    total++; if (bus.src_ready !== 1'b0) $display("FAIL b2b_full_after_one got %b exp 0", bus.src_ready); else passed++;
    bus.rd_n = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp = (k < 15) ? 16'h010A + 16'(k) : 16'h01FF;
      total++; if (bus.data_o !== exp) $display("FAIL b2b_order[%0d] got %h exp %h", k, bus.data_o, exp); else passed++;
      step();
    end
    bus.rd_n = 1'b1; bus.oe_n = 1'b1; step();
    total++; if (bus.rxf_n !== 1'b1) $display("FAIL b2b_final_rxf_n got %b exp 1", bus.rxf_n); else passed++;
  endtask

  task automatic test_proto_err();
    do_reset();
    bus.src_valid = 1'b1; bus.src_data = 16'hAAAA; step();
    bus.src_valid = 1'b0;
    bus.oe_n = 1'b0; step();
    bus.rd_n = 1'b0; step();
    bus.wr_n = 1'b0; bus.data_i = 16'hBEEF; step();
    total++; if (bus.proto_err !== 1'b1) $display("FAIL perr_set got %b exp 1", bus.proto_err); else passed++;
    total++; if (bus.snk_valid !== 1'b0) $display("FAIL perr_no_push got %b exp 0", bus.snk_valid); else passed++;
    total++; if (bus.wr_words !== 16'd0) $display("FAIL perr_wr_words got %0d exp 0", bus.wr_words); else passed++;
    idle_inputs(); step(); step();
    total++; if (bus.proto_err !== 1'b1) $display("FAIL perr_sticky got %b exp 1", bus.proto_err); else passed++;
    do_reset();
    total++; if (bus.proto_err !== 1'b0) $display("FAIL perr_cleared got %b exp 0", bus.proto_err); else passed++;
    bus.oe_n = 1'b0; step();
    bus.rd_n = 1'b0; step(); step();
    total++; if (bus.proto_err !== 1'b0) $display("FAIL perr_empty_read got %b exp 0", bus.proto_err); else passed++;
    total++; if (bus.rd_words !== 16'd0) $display("FAIL perr_empty_rd_words got %0d exp 0", bus.rd_words); else passed++;
    idle_inputs(); step();
    bus.oe_n = 1'b0; bus.wr_n = 1'b0; step();
    total++; if (bus.proto_err !== 1'b1) $display("FAIL perr_conflict got %b exp 1", bus.proto_err); else passed++;
    total++; if (bus.bus_oe !== 1'b0) $display("FAIL perr_conflict_idle got %b exp 0", bus.bus_oe); else passed++;
    total++; if (bus.wr_words !== 16'd0) $display("FAIL perr_conflict_push got %0d exp 0", bus.wr_words); else passed++;
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.src_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.src_data = 16'h0050 + 16'(i);
      step();
    end
    bus.src_valid = 1'b0;
    bus.oe_n = 1'b0; step();
    bus.rd_n = 1'b0; step(); step();
    total++; if (bus.data_o !== 16'h0052) $display("FAIL mid_data_o got %h exp 0052", bus.data_o); else passed++;
    rst = 1'b1; step();
    total++; if (bus.rxf_n !== 1'b1) $display("FAIL mid_rxf_n got %b exp 1", bus.rxf_n); else passed++;
    total++; if (bus.bus_oe !== 1'b0) $display("FAIL mid_bus_oe got %b exp 0", bus.bus_oe); else passed++;
    total++; if (bus.rd_words !== 16'd0) $display("FAIL mid_rd_words got %0d exp 0", bus.rd_words); else passed++;
    total++; if (bus.data_o !== 16'h0) $display("FAIL mid_data_o_cleared got %h exp 0", bus.data_o); else passed++;
    bus.wr_n = 1'b0; step(); step();
    total++; if (bus.bus_oe !== 1'b0) $display("FAIL held_bus_oe got %b exp 0", bus.bus_oe); else passed++;
    total++; if (bus.proto_err !== 1'b0) $display("FAIL held_proto_err got %b exp 0", bus.proto_err); else passed++;
    total++; if (bus.wr_words !== 16'd0) $display("FAIL held_wr_words got %0d exp 0", bus.wr_words); else passed++;
    idle_inputs(); rst = 1'b0; step();
    total++; if (bus.rxf_n !== 1'b1) $display("FAIL mid_after_release got %b exp 1", bus.rxf_n); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    bus.snk_ready = 1'b1; bus.oe_n = 1'b1; bus.be_i = 2'b11;
    bus.data_i = 16'h1234; bus.wr_n = 1'b0;
    repeat (65537) step();
    bus.wr_n = 1'b1; step();
    total++; if (bus.wr_words !== 16'h0001) $display("FAIL wrap_wr_words got %h exp 0001", bus.wr_words); else passed++;
    total++; if (bus.txe_n !== 1'b0) $display("FAIL wrap_txe_n got %b exp 0", bus.txe_n); else passed++;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_read_burst();
    test_write_full();
    test_back_to_back();
    test_proto_err();
    test_reset_mid_burst();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ft_slave_fifo.md
FT_SLAVE_FIFO -- requirements
Module: ft_slave_fifo

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set entries per buffer (power of 2, 4..256).
REQ-002 Parameter AW, default 4, SHALL set buffer address width (log2 DEPTH).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset.
REQ-006 Port wr_n, input, 1: master write strobe (FT600 WR_N).
REQ-007 Port rd_n, input, 1: master read strobe (FT600 RD_N).
REQ-008 Port oe_n, input, 1: master output enable (FT600 OE_N).
REQ-009 Port data_i, input, 16: bus data from the master.
REQ-010 Port be_i, input, 2: byte enables from the master.
REQ-011 Port data_o, output, 16: bus data toward the master.
REQ-012 Port be_o, output, 2: byte enables toward the master.
REQ-013 Port bus_oe, output, 1: drive enable for data_o/be_o pads.
REQ-014 Port rxf_n, output, 1: low = read buffer non-empty.
REQ-015 Port txe_n, output, 1: low = write buffer has space.
REQ-016 Ports src_valid/src_ready, input/output, 1 each: local load handshake; src_data 16, src_be 2 inputs.
REQ-017 Ports snk_valid/snk_ready, output/input, 1 each: local drain handshake; snk_data 16, snk_be 2 outputs.
REQ-018 Port proto_err, output, 1: sticky bus protocol violation.
REQ-019 Ports rd_words/wr_words, output, 16 each: words popped by master reads / pushed by master writes.

Function
REQ-020 Read buffer (RB) SHALL be a DEPTH-entry 18-bit FIFO; push on src_valid&&src_ready, src_ready = RB not full.
REQ-021 Write buffer (WB) SHALL be a DEPTH-entry 18-bit FIFO; pop on snk_valid&&snk_ready, snk_valid = WB not empty, snk_data/snk_be = WB head.
REQ-022 rxf_n and txe_n SHALL be registered, loaded each cycle from next-state counts: rxf_n <= (RB count_next==0), txe_n <= (WB count_next==DEPTH).
REQ-023 Bus FSM states: IDLE, OE, READ, WRITE.
REQ-024 IDLE->OE when oe_n=0 and wr_n=1; IDLE->WRITE when wr_n=0 and oe_n=1; both low SHALL stay IDLE and set proto_err.
REQ-025 OE->READ when rd_n=0; OE/READ->IDLE when oe_n=1; WRITE->IDLE when wr_n=1.
REQ-026 bus_oe SHALL equal 1 exactly when state is OE or READ.
REQ-027 data_o/be_o SHALL present RB head combinationally, and all zeros when RB empty.
REQ-028 Master pop SHALL occur on a clock edge with state in {OE,READ}, rd_n=0, rxf_n=0; next word appears the following cycle (zero-wait burst).
REQ-029 Master push SHALL occur on a clock edge with state in {IDLE,WRITE}, wr_n=0, oe_n=1, txe_n=0; capture data_i/be_i that edge.
REQ-030 Simultaneous local push and master pop on RB (or master push and local pop on WB) SHALL both complete, count unchanged.
REQ-031 rd_n=0 with rxf_n=1, or wr_n=0 with txe_n=1, SHALL be ignored (no pointer change) and SHALL NOT set proto_err.
REQ-032 proto_err SHALL set on: wr_n=0 in OE/READ; rd_n=0 in IDLE/WRITE; REQ-024 conflict; cleared only by rst.
REQ-033 Pointers SHALL wrap modulo DEPTH; counts SHALL be AW+1 bits; rd_words/wr_words SHALL wrap 0xFFFF->0x0000.

Reset
REQ-034 On rst=1 at a clock edge: state IDLE, both FIFOs empty, rxf_n=1, txe_n=0, proto_err=0, rd_words=wr_words=0, src_ready=1, snk_valid=0, bus_oe=0.
REQ-035 Reset mid-burst SHALL discard buffered data; held rst SHALL ignore all strobes.

Verification
REQ-036 Load 0x1111,0x2222,0x3333 via src; oe_n=0 cycle N, rd_n=0 cycles N+1..N+3 -> data_o 0x1111,0x2222,0x3333 on consecutive cycles, rxf_n=1 after third pop, rd_words=3.
REQ-037 Master writes 16 words 0x0000..0x000F, snk_ready=0 -> txe_n=1 after 16th push; 17th strobe ignored; drain yields 0x0000..0x000F, be=2'b11.
REQ-038 RB at 15 entries, simultaneous src push and master pop for 10 cycles -> count stays 15, order preserved, src_ready stays 1.
REQ-039 wr_n=0 while state READ -> proto_err=1, no WB push, remains 1 until rst.
REQ-040 rst asserted during a 4-word read burst with 8 queued -> next cycle rxf_n=1, bus_oe=0, rd_words=0.
REQ-041 Push 65537 words through WB -> wr_words=0x0001.
